// File: rtl/led_display_arbiter_pkg.sv
// Shared encodings and constants for the two-requester LED display arbiter.
package led_display_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam int unsigned DWELL_DEFAULT = 1000;
  localparam int unsigned CNT_W         = 16;

  // Digit slices within a 12-bit requester value; digit 0 is the rightmost.
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned DIG0_LSB = 0;
  localparam int unsigned DIG1_LSB = 4;
  localparam int unsigned DIG2_LSB = 8;

endpackage

// File: rtl/led_display_arbiter_dwell_timer.sv
// Saturating ownership timer: clears on a grant change, counts owned cycles up to limit.
module dwell_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/led_display_arbiter.sv
// Grants a 3-digit LED display to one of two requesters with a minimum dwell before preemption.
module led_display_arbiter
  import led_display_arbiter_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic [11:0] val_a,
  input  logic        req_b,
  input  logic [11:0] val_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  x0,
  output logic [3:0]  x1,
  output logic [3:0]  x2,
  output logic        blank
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DWELL - 1);

  state_e             state, state_next;
  logic               last_a, last_a_next;
  logic               done;
  logic               gnt_a_next, gnt_b_next, blank_next;
  logic [DIGIT_W-1:0] x0_next, x1_next, x2_next;

  dwell_timer #(
    .W(CNT_W)
  ) u_dwell (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_next != state),
    .enable (state != IDLE),
    .limit  (LIMIT),
    .done   (done)
  );

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      last_a <= 1'b0;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      x0     <= '0;
      x1     <= '0;
      x2     <= '0;
      blank  <= 1'b1;
    end else begin
      state  <= state_next;
      last_a <= last_a_next;
      gnt_a  <= gnt_a_next;
      gnt_b  <= gnt_b_next;
      x0     <= x0_next;
      x1     <= x1_next;
      x2     <= x2_next;
      blank  <= blank_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_a && req_b) state_next = last_a ? OWN_B : OWN_A;
        else if (req_a)     state_next = OWN_A;
        else if (req_b)     state_next = OWN_B;
      end
      OWN_A: begin
        if (!req_a)            state_next = req_b ? OWN_B : IDLE;
        else if (req_b && done) state_next = OWN_B;
      end
      OWN_B: begin
        if (!req_b)            state_next = req_a ? OWN_A : IDLE;
        else if (req_a && done) state_next = OWN_A;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they land on the same edge as the grant.
  always_comb begin
    gnt_a_next  = (state_next == OWN_A);
    gnt_b_next  = (state_next == OWN_B);
    blank_next  = (state_next == IDLE);
    last_a_next = last_a;
    x0_next     = x0;
    x1_next     = x1;
    x2_next     = x2;
    unique case (state_next)
      OWN_A: begin
        last_a_next = 1'b1;
        x0_next     = val_a[DIG0_LSB +: DIGIT_W];
        x1_next     = val_a[DIG1_LSB +: DIGIT_W];
        x2_next     = val_a[DIG2_LSB +: DIGIT_W];
      end
      OWN_B: begin
        last_a_next = 1'b0;
        x0_next     = val_b[DIG0_LSB +: DIGIT_W];
        x1_next     = val_b[DIG1_LSB +: DIGIT_W];
        x2_next     = val_b[DIG2_LSB +: DIGIT_W];
      end
      default: ;
    endcase
  end

endmodule
